tmp101_read_sequencer: RTL and testbench



---
 rtl/tmp101_read_sequencer.sv | 167 ++++++++++++++++
 tb/tb_tmp101_read_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmp101_read_sequencer.sv
// Periodic TMP101 read sequencer: pulses Go to the I2C master, collects MSB/LSB, publishes 12-bit temperature.
// Optional hysteretic alert comparator is built only when TMP_ALERT_EN is defined.
module tmp101_read_sequencer #(
  parameter int unsigned SAMPLE_PERIOD  = 60000000,
  parameter int unsigned TIMEOUT_CYCLES = 600000,
  parameter logic [11:0] ALERT_HIGH     = 12'h1E0,
  parameter logic [11:0] ALERT_LOW      = 12'h1A0
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        Busy,
  input  logic        ByteReady,
  input  logic [7:0]  ReceivedData,
  output logic        Go,
  output logic [11:0] Temperature,
  output logic        TempValid,
  output logic        Error,
  output logic        Alert
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_MSB,
    S_WAIT_LSB, S_WAIT_DONE, S_PUBLISH, S_FAULT
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_period;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_msb;
  logic [3:0]      r_lsb;
  logic [11:0]     r_temp;
  logic            r_go;
  logic            r_tv;
  logic            r_err;

  logic            w_start_req;
  logic            w_tmo;
  logic            w_in_wait;
  logic [11:0]     w_new_temp;
  logic            w_unused;

  assign w_start_req = Enable && (r_period == PW'(SAMPLE_PERIOD - 1));
  assign w_tmo       = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_in_wait   = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_MSB) ||
                       (r_state == S_WAIT_LSB)  || (r_state == S_WAIT_DONE);
  assign w_new_temp  = {r_msb, r_lsb};

  // Free-running period counter; requests that land outside IDLE are simply lost.
  always_ff @(posedge clock) begin
    if (Reset || !Enable) begin
      r_period <= '0;
    end else if (r_period == PW'(SAMPLE_PERIOD - 1)) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_msb   <= '0;
      r_lsb   <= '0;
      r_temp  <= '0;
      r_go    <= 1'b0;
      r_tv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_go  <= 1'b0;
      r_tv  <= 1'b0;
      r_tmo <= w_in_wait ? r_tmo + TW'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (w_start_req) begin
            r_state <= S_START;
            r_go    <= 1'b1;
          end
        end
        S_START: r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (Busy) begin
            r_state <= S_WAIT_MSB;
            r_tmo   <= '0;
          end else if (w_tmo) begin
            r_state <= S_FAULT;
            r_err   <= 1'b1;
            r_tmo   <= '0;
          end
        end
        S_WAIT_MSB: begin
          if (ByteReady) begin
            r_msb   <= ReceivedData;
            r_state <= S_WAIT_LSB;
            r_tmo   <= '0;
          end else if (!Busy || w_tmo) begin
            r_state <= S_FAULT;
            r_err   <= 1'b1;
            r_tmo   <= '0;
          end
        end
        S_WAIT_LSB: begin
          // Last byte and stop can coincide; go straight to publishing then.
          if (ByteReady) begin
            r_lsb   <= ReceivedData[7:4];
            r_state <= Busy ? S_WAIT_DONE : S_PUBLISH;
            r_tmo   <= '0;
          end else if (!Busy || w_tmo) begin
            r_state <= S_FAULT;
            r_err   <= 1'b1;
            r_tmo   <= '0;
          end
        end
        S_WAIT_DONE: begin
          if (ByteReady || (Busy && w_tmo)) begin
            r_state <= S_FAULT;
            r_err   <= 1'b1;
            r_tmo   <= '0;
          end else if (!Busy) begin
            r_state <= S_PUBLISH;
            r_tmo   <= '0;
          end
        end
        S_PUBLISH: begin
          r_temp  <= w_new_temp;
          r_tv    <= 1'b1;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Go          = r_go;
  assign Temperature = r_temp;
  assign TempValid   = r_tv;
  assign Error       = r_err;

`ifdef TMP_ALERT_EN
  logic r_alert;

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_alert <= 1'b0;
    end else if (r_state == S_PUBLISH) begin
      if ($signed(w_new_temp) >= $signed(ALERT_HIGH)) begin
        r_alert <= 1'b1;
      end else if ($signed(w_new_temp) <= $signed(ALERT_LOW)) begin
        r_alert <= 1'b0;
      end
    end
  end

  assign Alert    = r_alert;
  assign w_unused = ^ReceivedData[3:0];
`else
  assign Alert    = 1'b0;
  assign w_unused = ^{ReceivedData[3:0], ALERT_HIGH, ALERT_LOW};
`endif

endmodule

// File: tb/tb_tmp101_read_sequencer.sv
// Directed bench for tmp101_read_sequencer: table of read transactions plus reset/enable/alert sequences.
module tb_tmp101_read_sequencer;
  localparam int P = 200;
  localparam int T = 50;
  localparam int M_OK = 0, M_NOBUSY = 1, M_DROP = 2, M_SAMECYC = 3, M_EXTRA = 4;

  logic        clock = 1'b0;
  logic        Reset, Enable, Busy, ByteReady;
  logic [7:0]  ReceivedData;
  logic        Go, TempValid, Error, Alert;
  logic [11:0] Temperature;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tv_cnt  = 0;
  int go_cnt  = 0;

  typedef struct {
    int          mode;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    logic [11:0] temp;
    logic        err;
    int          tv;
  } vec_t;

  vec_t vt[10];

  tmp101_read_sequencer #(
    .SAMPLE_PERIOD (P),
    .TIMEOUT_CYCLES(T),
    .ALERT_HIGH    (12'h1E0),
    .ALERT_LOW     (12'h1A0)
  ) dut (
    .clock       (clock),
    .Reset       (Reset),
    .Enable      (Enable),
    .Busy        (Busy),
    .ByteReady   (ByteReady),
    .ReceivedData(ReceivedData),
    .Go          (Go),
    .Temperature (Temperature),
    .TempValid   (TempValid),
    .Error       (Error),
    .Alert       (Alert)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (TempValid) tv_cnt <= tv_cnt + 1;
    if (Go) go_cnt <= go_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_go(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (Go) begin
        at = cyc;
        break;
      end
    end
    n_tests++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL go_wait: no Go within %0d cycles, expected one", budget);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ByteReady    = 1'b1;
    ReceivedData = b;
    @(negedge clock);
    ByteReady    = 1'b0;
    ReceivedData = 8'h00;
  endtask

  // TempValid is expected on the second falling edge after the last master event.
  task automatic publish_latency(input string name);
    int lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      ByteReady    = 1'b0;
      ReceivedData = 8'h00;
      if (TempValid) begin
        lat = k;
        break;
      end
    end
    check(name, lat, 2);
  endtask

  // Master model; called on the falling edge where Go was seen.
  task automatic serve(input int mode, input logic [7:0] msb, input logic [7:0] lsb);
    int lat = 0;
    if (mode == M_NOBUSY) begin
      for (int k = 1; k <= 100; k++) begin
        @(negedge clock);
        if (Error) begin
          lat = k;
          break;
        end
      end
      // WAIT_BUSY is entered at the edge after Go; Error follows TIMEOUT cycles later.
      check("timeout_latency", lat, T + 1);
      return;
    end
    @(negedge clock);
    Busy = 1'b1;
    repeat (3) @(negedge clock);
    send_byte(msb);
    if (mode == M_DROP) begin
      Busy = 1'b0;
      return;
    end
    repeat (2) @(negedge clock);
    if (mode == M_SAMECYC) begin
      ByteReady    = 1'b1;
      ReceivedData = lsb;
      Busy         = 1'b0;
      publish_latency("samecyc_latency");
      return;
    end
    send_byte(lsb);
    repeat (2) @(negedge clock);
    if (mode == M_EXTRA) begin
      send_byte(8'hAA);
      repeat (2) @(negedge clock);
      Busy = 1'b0;
      return;
    end
    Busy = 1'b0;
    publish_latency("publish_latency");
  endtask

  initial begin
    int at, prev_go, tv0, g0, e0, rc;

    vt[0] = '{M_OK,      8'h19, 8'h00, 12'h190, 1'b0, 1};
    vt[1] = '{M_OK,      8'hE7, 8'h00, 12'hE70, 1'b0, 1};
    vt[2] = '{M_OK,      8'h19, 8'h5F, 12'h195, 1'b0, 1};
    vt[3] = '{M_NOBUSY,  8'h00, 8'h00, 12'h195, 1'b1, 0};
    vt[4] = '{M_OK,      8'h19, 8'h00, 12'h190, 1'b0, 1};
    vt[5] = '{M_DROP,    8'hAA, 8'h00, 12'h190, 1'b1, 0};
    vt[6] = '{M_OK,      8'h7F, 8'hF0, 12'h7FF, 1'b0, 1};
    vt[7] = '{M_SAMECYC, 8'h80, 8'h00, 12'h800, 1'b0, 1};
    vt[8] = '{M_OK,      8'hC9, 8'h30, 12'hC93, 1'b0, 1};
    vt[9] = '{M_EXTRA,   8'h12, 8'h34, 12'hC93, 1'b1, 0};

    Reset = 1'b1; Enable = 1'b1; Busy = 1'b0; ByteReady = 1'b0; ReceivedData = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_go", Go, 0);
    check("rst_temp", Temperature, 0);
    check("rst_tv", TempValid, 0);
    check("rst_err", Error, 0);
    check("rst_alert", Alert, 0);
    Reset   = 1'b0;
    prev_go = cyc;

    for (int i = 0; i < 10; i++) begin
      wait_go(2 * P, at);
      check($sformatf("v%0d_go_period", i), at - prev_go, P);
      prev_go = at;
      tv0 = tv_cnt;
      serve(vt[i].mode, vt[i].msb, vt[i].lsb);
      repeat (60) @(negedge clock);
      check($sformatf("v%0d_temp", i), Temperature, vt[i].temp);
      check($sformatf("v%0d_err", i), Error, vt[i].err);
      check($sformatf("v%0d_tv_cycles", i), tv_cnt - tv0, vt[i].tv);
`ifndef TMP_ALERT_EN
      check($sformatf("v%0d_alert", i), Alert, 0);
`endif
    end

    // Enable low: period counter held, no Go; restart takes a full period.
    Enable = 1'b0;
    g0 = go_cnt;
    repeat (450) @(negedge clock);
    check("disabled_no_go", go_cnt - g0, 0);
    Enable = 1'b1;
    e0 = cyc;
    wait_go(2 * P, at);
    check("enable_first_go", at - e0, P);

    // Reset pulse while waiting for the LSB.
    @(negedge clock);
    Busy = 1'b1;
    repeat (2) @(negedge clock);
    send_byte(8'h19);
    Reset = 1'b1;
    @(negedge clock);
    check("midrst_go", Go, 0);
    check("midrst_temp", Temperature, 0);
    check("midrst_err", Error, 0);
    check("midrst_tv", TempValid, 0);
    Reset = 1'b0;
    rc  = cyc;
    tv0 = tv_cnt;
    repeat (2) @(negedge clock);
    send_byte(8'h00);
    Busy = 1'b0;
    wait_go(2 * P, at);
    check("midrst_first_go", at - rc, P);
    check("midrst_no_tv", tv_cnt - tv0, 0);
    serve(M_OK, 8'h19, 8'h00);
    repeat (5) @(negedge clock);
    check("recover_temp", Temperature, 12'h190);
    check("recover_err", Error, 0);

`ifdef TMP_ALERT_EN
    wait_go(2 * P, at);
    serve(M_OK, 8'h1E, 8'h00);
    repeat (2) @(negedge clock);
    check("alert_set", Alert, 1);
    wait_go(2 * P, at);
    serve(M_OK, 8'h1C, 8'h00);
    repeat (2) @(negedge clock);
    check("alert_hold", Alert, 1);
    wait_go(2 * P, at);
    serve(M_OK, 8'h19, 8'h00);
    repeat (2) @(negedge clock);
    check("alert_clear", Alert, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
